// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store controller.
//   Size encodings for req_size, the controller state type and the
//   byte-lane geometry of a data-memory word.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned LANE_COUNT = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_W     = LANE_COUNT * LANE_W;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

endpackage

// File: rtl/lane_align.sv
// Purely combinational byte-lane logic for the load/store controller.
//   addr_i       low two address bits of the access
//   size_i       access size (lsu_pkg SZ_*)
//   unsigned_i   1 = zero-extend loads, 0 = sign-extend
//   wdata_i      store data, sub-word value in the low bits
//   mem_word_i   word currently read from data memory
//   aligned_o    access is legal for its size
//   load_data_o  addressed lane(s) extracted and extended
//   merge_word_o mem_word_i with the addressed lane(s) replaced by wdata_i
module lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] mem_word_i,
  output logic              aligned_o,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merge_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_bit;

  // Little-endian: byte k sits at bits [8k+7:8k]; halfword picked by addr[1].
  assign byte_lane = mem_word_i[{addr_i, 3'b000} +: 8];
  assign half_lane = addr_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

  always_comb begin
    aligned_o    = 1'b0;
    load_data_o  = mem_word_i;
    merge_word_o = mem_word_i;
    sign_bit     = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        aligned_o   = 1'b1;
        sign_bit    = ~unsigned_i & byte_lane[7];
        load_data_o = {{24{sign_bit}}, byte_lane};
        merge_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        aligned_o   = ~addr_i[0];
        sign_bit    = ~unsigned_i & half_lane[15];
        load_data_o = {{16{sign_bit}}, half_lane};
        merge_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SZ_WORD: begin
        aligned_o    = (addr_i == 2'b00);
        merge_word_o = wdata_i;
      end
      default: begin
        aligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Multi-cycle load/store controller in front of the word-only data memory.
// Byte/half/word loads and stores become word accesses; sub-word stores use
// read-modify-write. Misaligned or reserved-size requests are rejected
// without touching memory.
//   clock, reset     clock and asynchronous active-high reset
//   req*             CPU request (sampled only while idle)
//   busy             high whenever not idle
//   done             one-cycle completion pulse, qualified by misaligned
//   rdata            extended load result, held until the next good load
//   dm_*             word interface to the data memory (combinational read)
module dm_access_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [DATA_W-1:0] rdata,
  output logic              dm_mem_write,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  input  logic [DATA_W-1:0] dm_data_out
);

  state_e              state_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   merge_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                idle;
  logic [1:0]          la_addr;
  logic [1:0]          la_size;
  logic                la_aligned;
  logic [DATA_W-1:0]   la_load_data;
  logic [DATA_W-1:0]   la_merge_word;

  assign idle = (state_q == StIdle);

  // While idle the lane logic judges the incoming request's alignment;
  // afterwards it works on the latched request.
  assign la_addr = idle ? req_addr[1:0] : addr_q[1:0];
  assign la_size = idle ? req_size      : size_q;

  lane_align u_lane_align (
    .addr_i       (la_addr),
    .size_i       (la_size),
    .unsigned_i   (unsigned_q),
    .wdata_i      (wdata_q),
    .mem_word_i   (dm_data_out),
    .aligned_o    (la_aligned),
    .load_data_o  (la_load_data),
    .merge_word_o (la_merge_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      merge_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= ~la_aligned;
            if (!la_aligned) begin
              state_q <= StResp;
            end else if (req_write && (req_size == SZ_WORD)) begin
              merge_q <= req_wdata;
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (write_q) begin
            merge_q <= la_merge_word;
            state_q <= StWrite;
          end else begin
            rdata_q <= la_load_data;
            state_q <= StResp;
          end
        end
        StWrite: state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // All handshake and memory-strobe outputs decode the state register only,
  // so reset clears them immediately and dm_mem_write cannot glitch.
  assign busy         = ~idle;
  assign done         = (state_q == StResp);
  assign misaligned   = done & err_q;
  assign rdata        = rdata_q;
  assign dm_mem_write = (state_q == StWrite);
  assign dm_address   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_data_in   = merge_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, misaligned, dm_mem_write;
  logic [31:0] rdata, dm_address, dm_data_in, dm_data_out;

  int checks = 0;
  int errors = 0;

  // Data memory seen by the DUT, plus a loader used only while in reset.
  logic [31:0] mem [64];
  logic        init_we = 1'b0;
  logic [5:0]  init_idx = '0;
  logic [31:0] init_val = '0;

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [31:0] model_rdata = '0;

  always #5 clock = ~clock;

  dm_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .misaligned   (misaligned),
    .rdata        (rdata),
    .dm_mem_write (dm_mem_write),
    .dm_address   (dm_address),
    .dm_data_in   (dm_data_in),
    .dm_data_out  (dm_data_out)
  );

  assign dm_data_out = mem[dm_address[7:2]];

  always @(posedge clock) begin
    if (init_we) mem[init_idx] <= init_val;
    else if (dm_mem_write) mem[dm_address[7:2]] <= dm_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request through the DUT, checked against the model.
  task automatic do_access(input string tag, input logic wr, input logic [1:0] sz,
                           input logic un, input logic [31:0] ad, input logic [31:0] wd);
    int          n;
    int          writes;
    int          off;
    int          exp_lat;
    logic        mis;
    logic [31:0] w, v, mask, new_w;
    n = 0;
    @(negedge clock);
    while (busy && n < 10) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    off  = int'(ad[1:0]);
    mis  = (sz == 2'b11) || ((ad % (32'd1 << sz)) != 0);
    w    = ref_mem[ad[7:2]];
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * off);
    new_w = (w & ~mask) | ((wd << (8 * off)) & mask);
    exp_lat = mis ? 1 : (!wr || sz == 2'b10) ? 2 : 3;

    req = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 1;
    writes = 0;
    while (!done && n < 8) begin
      if (dm_mem_write) begin
        writes++;
        check({tag, "_waddr"}, dm_address, ad & ~32'd3);
        check({tag, "_wdata"}, dm_data_in, new_w);
      end
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_misaligned"}, {31'b0, misaligned}, {31'b0, mis});
    check({tag, "_writes"}, writes, (wr && !mis) ? 1 : 0);
    if (!mis && !wr) begin
      if (sz == 2'b00) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (!un && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (!un && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      model_rdata = v;
    end
    if (!mis && wr) ref_mem[ad[7:2]] = new_w;
    check({tag, "_rdata"}, rdata, model_rdata);
    @(negedge clock);
    check({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    logic        wr, un;
    logic [1:0]  sz;
    logic [31:0] ad;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h80FF_7F80;
    ref_mem[8] = 32'h1122_3344;
    ref_mem[12] = 32'hCAFE_F00D;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      init_we = 1'b1; init_idx = 6'(i); init_val = ref_mem[i];
    end
    @(negedge clock);
    init_we = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_mis", {31'b0, misaligned}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_memwr", {31'b0, dm_mem_write}, 32'd0);
    check("reset_addr", dm_address, 32'd0);
    check("reset_din", dm_data_in, 32'd0);
    reset = 1'b0;

    do_access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_access("lw10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    check("lw10_const", rdata, 32'hDEAD_BEEF);
    do_access("sb22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA);
    check("sb22_mem", mem[8], 32'h11AA_3344);
    do_access("lb0", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("lb0_const", rdata, 32'hFFFF_FF80);
    do_access("lbu0", 1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
    check("lbu0_const", rdata, 32'h0000_0080);
    do_access("lh2", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    check("lh2_const", rdata, 32'hFFFF_80FF);
    do_access("lhu2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    check("lhu2_const", rdata, 32'h0000_80FF);
    do_access("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    do_access("sh21", 1'b1, 2'b01, 1'b0, 32'h21, 32'h5555);
    do_access("sz11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("mis_rdata_kept", rdata, 32'h0000_80FF);

    // Request held across two loads: one idle cycle between them.
    @(negedge clock);
    req = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(negedge clock);
    check("held_read1", {31'b0, busy}, 32'd1);
    @(negedge clock);
    check("held_done1", {31'b0, done}, 32'd1);
    check("held_rdata1", rdata, ref_mem[4]);
    req_addr = 32'h20;
    @(negedge clock);
    check("held_gap", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("held_accept2", {31'b0, busy}, 32'd1);
    @(negedge clock);
    check("held_done2", {31'b0, done}, 32'd1);
    check("held_rdata2", rdata, ref_mem[8]);
    model_rdata = ref_mem[8];
    req = 1'b0;

    // Reset during the READ of a halfword store.
    @(negedge clock);
    @(negedge clock);
    req = 1'b1; req_write = 1'b1; req_size = 2'b01; req_addr = 32'h32; req_wdata = 32'h1234;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    check("rst_in_read", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_memwr", {31'b0, dm_mem_write}, 32'd0);
    check("rst_addr", dm_address, 32'd0);
    check("rst_din", dm_data_in, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    model_rdata = '0;
    @(posedge clock);
    @(negedge clock);
    check("rst_no_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    check("rst_mem_kept", mem[12], 32'hCAFE_F00D);
    do_access("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      un = 1'($urandom);
      ad = $urandom_range(0, 255);
      do_access($sformatf("rnd%0d", i), wr, sz, un, ad, $urandom);
    end

    for (int i = 0; i < 64; i++) check($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
